// File: rtl/program_loader.sv
// Instruction-memory loader: accepts a counted stream of 32-bit words, writes them
// to consecutive word addresses, then holds the core in reset for a flush window.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | after reset, waiting for start; core held in reset
// LOAD     | accepting words, one memory write per accepted word
// FLUSH    | final word written, core_reset held for FLUSH_CYCLES cycles
// RUN      | core released, done=1; a valid start reloads
// ERROR    | bad word_count or idle timeout; a valid start retries

module program_loader #(
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 1000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  in_valid,
   input  logic [31:0]           in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [31:0]           imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output logic [31:0]           checksum
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_FLUSH = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_ERROR = 3'd4;

   // Down-counter reload values: terminal count is zero, so load N-1 for N cycles.
   localparam logic [31:0] IDLE_TC  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
   localparam logic [31:0] FLUSH_TC = (FLUSH_CYCLES > 0) ? 32'(FLUSH_CYCLES - 1) : 32'd0;
   localparam logic [2:0]  ST_AFTER_LOAD = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_RUN;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] word_total_q, word_total_d;
   logic [31:0]   idle_cnt_q, idle_cnt_d;
   logic [31:0]   flush_cnt_q, flush_cnt_d;
   logic          in_ready_q, in_ready_d;
   logic          imem_we_q, imem_we_d;
   logic [31:0]   imem_addr_q, imem_addr_d;
   logic [31:0]   imem_wdata_q, imem_wdata_d;
   logic          core_reset_q, core_reset_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [CW-1:0] words_loaded_q, words_loaded_d;
   logic [31:0]   checksum_q, checksum_d;

   logic          count_ok;
   logic          handshake;
   logic          last_word;

   // Valid range is 1..2^ADDR_WIDTH; the MSB alone is only legal for exactly MAX_WORDS.
   assign count_ok  = (word_count != '0) &&
                      ((word_count[ADDR_WIDTH] == 1'b0) || (word_count[ADDR_WIDTH-1:0] == '0));
   assign handshake = (state_q == ST_LOAD) && in_ready_q && in_valid;
   assign last_word = ((words_loaded_q + CW'(1)) == word_total_q);

   always_comb begin
      state_d        = state_q;
      word_total_d   = word_total_q;
      idle_cnt_d     = idle_cnt_q;
      flush_cnt_d    = flush_cnt_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr_q;
      imem_wdata_d   = imem_wdata_q;
      words_loaded_d = words_loaded_q;
      checksum_d     = checksum_q;

      case (state_q)
         ST_IDLE, ST_RUN, ST_ERROR: begin
            if (start) begin
               if (count_ok) begin
                  state_d        = ST_LOAD;
                  word_total_d   = word_count;
                  words_loaded_d = '0;
                  checksum_d     = '0;
                  idle_cnt_d     = IDLE_TC;
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end

         ST_LOAD: begin
            if (handshake) begin
               imem_we_d      = 1'b1;
               imem_addr_d    = BASE_ADDR + (32'(words_loaded_q) << 2);
               imem_wdata_d   = in_data;
               words_loaded_d = words_loaded_q + CW'(1);
               checksum_d     = checksum_q + in_data;
               idle_cnt_d     = IDLE_TC;
               if (last_word) begin
                  state_d     = ST_AFTER_LOAD;
                  flush_cnt_d = FLUSH_TC;
               end
            end else if (idle_cnt_q == '0) begin
               state_d = ST_ERROR;
            end else begin
               idle_cnt_d = idle_cnt_q - 32'd1;
            end
         end

         ST_FLUSH: begin
            if (flush_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 32'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      in_ready_d   = (state_d == ST_LOAD);
      core_reset_d = (state_d != ST_RUN);
      done_d       = (state_d == ST_RUN);
      error_d      = (state_d == ST_ERROR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         word_total_q   <= '0;
         idle_cnt_q     <= '0;
         flush_cnt_q    <= '0;
         in_ready_q     <= 1'b0;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= '0;
         imem_wdata_q   <= '0;
         core_reset_q   <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         words_loaded_q <= '0;
         checksum_q     <= '0;
      end else begin
         state_q        <= state_d;
         word_total_q   <= word_total_d;
         idle_cnt_q     <= idle_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
         in_ready_q     <= in_ready_d;
         imem_we_q      <= imem_we_d;
         imem_addr_q    <= imem_addr_d;
         imem_wdata_q   <= imem_wdata_d;
         core_reset_q   <= core_reset_d;
         done_q         <= done_d;
         error_q        <= error_d;
         words_loaded_q <= words_loaded_d;
         checksum_q     <= checksum_d;
      end
   end

   // A reset arriving in the issue cycle of a write withholds that write from memory.
   assign imem_we      = imem_we_q & ~reset;
   assign in_ready     = in_ready_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign core_reset   = core_reset_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_loaded_q;
   assign checksum     = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: start-validity table, directed corner
// sequences and randomized load sessions against a transaction-level model.

module tb_program_loader;

   localparam int          AW    = 10;
   localparam int          WCW   = AW + 1;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          FLUSH = 4;
   localparam int          TMO   = 1000;

   logic           clock = 1'b0;
   logic           reset;
   logic           start;
   logic [WCW-1:0] word_count;
   logic           in_valid;
   logic [31:0]    in_data;
   logic           in_ready;
   logic           imem_we;
   logic [31:0]    imem_addr;
   logic [31:0]    imem_wdata;
   logic           core_reset;
   logic           done;
   logic           error;
   logic [WCW-1:0] words_loaded;
   logic [31:0]    checksum;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
   } wr_t;

   typedef struct {
      logic [WCW-1:0] wc;
      logic           exp_err;
      logic           exp_rdy;
   } start_vec_t;

   wr_t         exp_q[$];
   logic [31:0] sess_words[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc_n  = 0;

   program_loader #(
      .ADDR_WIDTH   (AW),
      .BASE_ADDR    (BASE),
      .FLUSH_CYCLES (FLUSH),
      .TIMEOUT      (TMO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .word_count   (word_count),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_reset   (core_reset),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded),
      .checksum     (checksum)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic rdy, input logic crst,
                           input logic dn, input logic er);
      chk({tag, "_in_ready"},   32'(in_ready),   32'(rdy));
      chk({tag, "_core_reset"}, 32'(core_reset), 32'(crst));
      chk({tag, "_done"},       32'(done),       32'(dn));
      chk({tag, "_error"},      32'(error),      32'(er));
   endtask

   task automatic chk_reset_values(input string tag);
      chk_outs(tag, 1'b0, 1'b1, 1'b0, 1'b0);
      chk({tag, "_imem_we"},      32'(imem_we),      32'd0);
      chk({tag, "_imem_addr"},    imem_addr,         32'd0);
      chk({tag, "_imem_wdata"},   imem_wdata,        32'd0);
      chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
      chk({tag, "_checksum"},     checksum,          32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Every write must appear exactly one cycle after the handshake that produced it.
   always @(negedge clock) begin
      wr_t w;
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_we", 32'(imem_we), 32'd0);
         end else begin
            w = exp_q.pop_front();
            chk("wr_cycle", 32'(cyc_n), 32'(w.due));
            chk("wr_addr",  imem_addr,  w.addr);
            chk("wr_data",  imem_wdata, w.data);
         end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc_n) begin
         void'(exp_q.pop_front());
         chk("missing_we", 32'(imem_we), 32'd1);
      end
   end

   // mode 0: back-to-back, 1: valid every other cycle, 2: random valid plus start noise
   task automatic run_load(input int mode);
      int          n, k, gap;
      logic        v, tog;
      logic [31:0] psum;
      n = sess_words.size();
      start = 1'b1; word_count = WCW'(n);
      step();
      start = 1'b0;
      chk_outs("load_entry", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("load_entry_words", 32'(words_loaded), 32'd0);
      chk("load_entry_sum",   checksum,          32'd0);
      k = 0; gap = 0; tog = 1'b0; psum = '0;
      while (k < n) begin
         chk("in_ready_load",     32'(in_ready),     32'd1);
         chk("words_loaded_load", 32'(words_loaded), 32'(k));
         chk("checksum_load",     checksum,          psum);
         case (mode)
            0:       v = 1'b1;
            1:       begin v = tog; tog = ~tog; end
            default: v = ($urandom_range(99) < 60) || (gap >= 4);
         endcase
         in_valid = v;
         in_data  = v ? sess_words[k] : $urandom;
         if (mode == 2) begin
            start      = 1'($urandom_range(1));
            word_count = WCW'($urandom);
         end
         if (v) begin
            exp_q.push_back('{addr: BASE + 32'(4 * k), data: sess_words[k], due: cyc_n + 1});
            psum += sess_words[k];
            k++;
            gap = 0;
         end else begin
            gap++;
         end
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < FLUSH; i++) begin
         chk_outs("flush", 1'b0, 1'b1, 1'b0, 1'b0);
         if (mode == 2) begin
            start      = 1'($urandom_range(1));
            word_count = WCW'($urandom);
         end
         step();
      end
      start = 1'b0;
      chk_outs("run", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("run_words_loaded", 32'(words_loaded), 32'(n));
      chk("run_checksum",     checksum,          psum);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = $urandom;
         step();
         chk("run_hold_done",  32'(done),         32'd1);
         chk("run_hold_words", 32'(words_loaded), 32'(n));
      end
      in_valid = 1'b0;
   endtask

   initial begin
      start_vec_t vecs[6];
      logic [31:0] w;

      vecs[0] = '{wc: WCW'(0),    exp_err: 1'b1, exp_rdy: 1'b0};
      vecs[1] = '{wc: WCW'(1025), exp_err: 1'b1, exp_rdy: 1'b0};
      vecs[2] = '{wc: WCW'(2047), exp_err: 1'b1, exp_rdy: 1'b0};
      vecs[3] = '{wc: WCW'(1),    exp_err: 1'b0, exp_rdy: 1'b1};
      vecs[4] = '{wc: WCW'(1024), exp_err: 1'b0, exp_rdy: 1'b1};
      vecs[5] = '{wc: WCW'(37),   exp_err: 1'b0, exp_rdy: 1'b1};

      reset = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
      step();
      step();
      chk_reset_values("reset");
      reset = 1'b0;
      step();
      chk_outs("idle", 1'b0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         start = 1'b1; word_count = vecs[i].wc;
         step();
         start = 1'b0;
         chk("tbl_error",      32'(error),        32'(vecs[i].exp_err));
         chk("tbl_in_ready",   32'(in_ready),     32'(vecs[i].exp_rdy));
         chk("tbl_core_reset", 32'(core_reset),   32'd1);
         chk("tbl_done",       32'(done),         32'd0);
         chk("tbl_words",      32'(words_loaded), 32'd0);
      end

      // Three-word program back-to-back, then the same image with in_valid toggling.
      do_reset();
      sess_words = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
      run_load(0);
      run_load(1);

      // Reload from RUN with a single word.
      sess_words = '{32'h0000_0013};
      run_load(0);

      // Invalid start from RUN, invalid retry from ERROR, then a valid retry.
      start = 1'b1; word_count = WCW'(0);
      step();
      start = 1'b0;
      chk_outs("run_bad_start", 1'b0, 1'b1, 1'b0, 1'b1);
      start = 1'b1; word_count = WCW'(2000);
      step();
      start = 1'b0;
      chk_outs("err_bad_start", 1'b0, 1'b1, 1'b0, 1'b1);
      sess_words = '{$urandom, $urandom};
      run_load(0);

      // Two invalid starts from IDLE: no writes, core held in reset.
      do_reset();
      start = 1'b1; word_count = WCW'(0);
      step();
      chk_outs("zero_count", 1'b0, 1'b1, 1'b0, 1'b1);
      word_count = WCW'(1025);
      step();
      start = 1'b0;
      chk_outs("over_count", 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      chk("over_count_core_reset", 32'(core_reset), 32'd1);

      // Timeout after one of two words.
      do_reset();
      start = 1'b1; word_count = WCW'(2);
      step();
      start = 1'b0;
      w = $urandom;
      in_valid = 1'b1; in_data = w;
      exp_q.push_back('{addr: BASE, data: w, due: cyc_n + 1});
      step();
      in_valid = 1'b0;
      for (int i = 0; i < TMO - 1; i++) step();
      chk("tmo_not_yet_error", 32'(error),    32'd0);
      chk("tmo_not_yet_rdy",   32'(in_ready), 32'd1);
      step();
      chk_outs("tmo", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("tmo_words_loaded", 32'(words_loaded), 32'd1);
      chk("tmo_checksum",     checksum,          w);

      // Reset in the issue cycle of the second write of a four-word load.
      do_reset();
      start = 1'b1; word_count = WCW'(4);
      step();
      start = 1'b0;
      w = $urandom;
      in_valid = 1'b1; in_data = w;
      exp_q.push_back('{addr: BASE, data: w, due: cyc_n + 1});
      step();
      w = $urandom;
      in_data = w;
      exp_q.push_back('{addr: BASE + 32'd4, data: w, due: cyc_n + 1});
      step();
      reset = 1'b1; in_data = $urandom;
      void'(exp_q.pop_back());
      step();
      chk_reset_values("midload_reset");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = $urandom;
         step();
         chk("post_reset_rdy",   32'(in_ready),     32'd0);
         chk("post_reset_words", 32'(words_loaded), 32'd0);
      end
      in_valid = 1'b0;

      // Randomized sessions, each one reloading from RUN.
      do_reset();
      for (int s = 0; s < 15; s++) begin
         sess_words.delete();
         for (int i = 0; i < int'($urandom_range(12, 1)); i++) sess_words.push_back($urandom);
         run_load(2);
      end

      step();
      step();
      chk("pending_writes", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
